// File: rtl/btn_pkg.sv
// Shared constants for the calculator push-button front end.
package btn_pkg;

  localparam int NUM_BTNS = 5;

  // Bit positions within the button vectors.
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_U = 2;
  localparam int BTN_R = 3;
  localparam int BTN_D = 4;

  // 10 ms of stability at 100 MHz.
  localparam int DEBOUNCE_DEFAULT = 1_000_000;

  typedef logic [NUM_BTNS-1:0] btn_vec_t;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: two-flop synchronizer, stability counter, debounced
// level and a registered rising-edge pulse.
module btn_debounce_ch
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic pulse
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
    $error("btn_debounce_ch: DEBOUNCE_CYCLES must be >= 2");
  end

  logic             s1_reg;
  logic             s2_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             lvl_reg;
  logic             lvl_next;
  logic             pulse_reg;
  logic             pulse_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_reg    <= 1'b0;
      s2_reg    <= 1'b0;
      cnt_reg   <= '0;
      lvl_reg   <= 1'b0;
      pulse_reg <= 1'b0;
    end else begin
      s1_reg    <= raw;
      s2_reg    <= s1_reg;
      cnt_reg   <= cnt_next;
      lvl_reg   <= lvl_next;
      pulse_reg <= pulse_next;
    end
  end

  // Any disagreement run shorter than DEBOUNCE_CYCLES is discarded by the
  // counter clearing as soon as s2 matches the accepted level again.
  always_comb begin
    cnt_next = '0;
    lvl_next = lvl_reg;
    if (s2_reg != lvl_reg) begin
      if (cnt_reg == CNT_MAX) begin
        lvl_next = s2_reg;
        cnt_next = '0;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end
    pulse_next = lvl_next & ~lvl_reg;
  end

  assign level = lvl_reg;
  assign pulse = pulse_reg;

endmodule

// File: rtl/btn_conditioner.sv
// Five independent debounce channels producing clean levels and press pulses
// for the calculator top level.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BTNS-1:0] btn_raw,
  output logic [NUM_BTNS-1:0] btn_level,
  output logic [NUM_BTNS-1:0] btn_pulse
);

  for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk  (clk),
      .rst  (rst),
      .raw  (btn_raw[gi]),
      .level(btn_level[gi]),
      .pulse(btn_pulse[gi])
    );
  end

endmodule
